// File: rtl/queue_entry_serializer_pkg.sv
// Shared types and defaults for the queue entry serializer and its upstream queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package queue_entry_serializer_pkg;

   localparam int DEF_ENTRY_W = 64;
   localparam int DEF_BEAT_W  = 16;

   // Counter width for n beats; a single-beat entry still gets a 1-bit field.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_NUM_BEATS  = DEF_ENTRY_W / DEF_BEAT_W;
   localparam int DEF_BEAT_CNT_W = cnt_width(DEF_NUM_BEATS);

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_SERIALIZE = 1'b1
   } state_e;

   // One queue slot: the entry plus its beat-count sideband (beats minus 1).
   typedef struct packed {
      logic [DEF_BEAT_CNT_W-1:0] len;
      logic [DEF_ENTRY_W-1:0]    data;
   } req_t;

endpackage

// File: rtl/fifo_queue.sv
// Generic first-word-fall-through queue with a valid/ack reader side.
// Latency: entry pushed at edge N is visible on request_out after edge N.
// Backpressure: push_ready_out low when full; head held until issue_ack_in.
module fifo_queue #(
   parameter int DATA_WIDTH_IN_BITS = 8,
   parameter int DEPTH              = 4
) (
   input  logic                          clk_in,
   input  logic                          reset_n_in,
   input  logic                          push_valid_in,
   output logic                          push_ready_out,
   input  logic [DATA_WIDTH_IN_BITS-1:0] push_data_in,
   output logic [DATA_WIDTH_IN_BITS-1:0] request_out,
   output logic                          request_valid_out,
   input  logic                          issue_ack_in
);

   // Pointers wrap naturally, so DEPTH must be a power of 2.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][DATA_WIDTH_IN_BITS-1:0] mem_q;
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   count_q;
   logic          push_fire, pop_fire;

   assign push_ready_out    = (count_q != (AW+1)'(DEPTH));
   assign request_valid_out = (count_q != '0);
   assign request_out       = mem_q[rd_ptr_q];
   assign push_fire         = push_valid_in & push_ready_out;
   assign pop_fire          = request_valid_out & issue_ack_in;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_fire)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_fire, pop_fire})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is data-only; stale contents are masked by request_valid_out.
   always_ff @(posedge clk_in) begin
      if (push_fire) mem_q[wr_ptr_q] <= push_data_in;
   end

endmodule

// File: rtl/queue_entry_serializer.sv
// Pops one wide queue entry and replays it LSB-first as narrow beats with a last flag.
// Latency: first beat registered 1 cycle after accept; 1 beat/cycle incl. entry boundaries.
// Backpressure: beat outputs hold while beat_ack_in low; queue acked only when idle or on last-beat ack.
module queue_entry_serializer
   import queue_entry_serializer_pkg::*;
#(
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS = DEF_ENTRY_W,
   parameter int BEAT_WIDTH_IN_BITS         = DEF_BEAT_W,
   parameter int NUM_BEATS                  = SINGLE_ENTRY_WIDTH_IN_BITS / BEAT_WIDTH_IN_BITS,
   parameter int BEAT_CNT_WIDTH_IN_BITS     = cnt_width(NUM_BEATS)
) (
   input  logic                                  clk_in,
   input  logic                                  reset_n_in,
   input  logic                                  flush_in,
   input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
   input  logic [BEAT_CNT_WIDTH_IN_BITS-1:0]     request_len_in,
   input  logic                                  request_valid_in,
   output logic                                  issue_ack_out,
   output logic [BEAT_WIDTH_IN_BITS-1:0]         beat_out,
   output logic                                  beat_valid_out,
   output logic                                  beat_last_out,
   input  logic                                  beat_ack_in,
   output logic                                  busy_out
);

   state_e                                state_q, state_d;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] entry_q, entry_d;
   logic [BEAT_CNT_WIDTH_IN_BITS-1:0]     len_q, len_d;
   logic [BEAT_CNT_WIDTH_IN_BITS-1:0]     cnt_q, cnt_d, cnt_nxt;
   logic [BEAT_WIDTH_IN_BITS-1:0]         beat_q, beat_d;
   logic                                  beat_vld_q, beat_vld_d;
   logic                                  beat_last_q, beat_last_d;
   logic                                  last_done, beat_adv, accept;

   // The queue ack only looks at local state and the downstream ack, never at
   // request_valid_in, so no combinational loop forms through the queue.
   assign last_done     = beat_vld_q & beat_last_q & beat_ack_in;
   assign issue_ack_out = ~flush_in & ((state_q == ST_IDLE) | last_done);
   assign accept        = issue_ack_out & request_valid_in;
   assign beat_adv      = beat_vld_q & beat_ack_in & ~beat_last_q;
   assign cnt_nxt       = cnt_q + BEAT_CNT_WIDTH_IN_BITS'(1);

   assign beat_out       = beat_q;
   assign beat_valid_out = beat_vld_q;
   assign beat_last_out  = beat_last_q;
   assign busy_out       = (state_q == ST_SERIALIZE);

   // Next state: flush beats everything, then accept (which also covers the
   // back-to-back case), then end of entry, then advance to the next beat.
   always_comb begin
      state_d     = state_q;
      entry_d     = entry_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      beat_d      = beat_q;
      beat_vld_d  = beat_vld_q;
      beat_last_d = beat_last_q;
      if (flush_in) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         beat_d      = '0;
         beat_vld_d  = 1'b0;
         beat_last_d = 1'b0;
      end else if (accept) begin
         state_d     = ST_SERIALIZE;
         entry_d     = request_in;
         len_d       = request_len_in;
         cnt_d       = '0;
         beat_d      = request_in[BEAT_WIDTH_IN_BITS-1:0];
         beat_vld_d  = 1'b1;
         beat_last_d = (request_len_in == '0);
      end else if (last_done) begin
         state_d     = ST_IDLE;
         beat_d      = '0;
         beat_vld_d  = 1'b0;
         beat_last_d = 1'b0;
      end else if (beat_adv) begin
         // Only advances while not on the last beat, so cnt never passes len.
         cnt_d       = cnt_nxt;
         beat_d      = entry_q[cnt_nxt * BEAT_WIDTH_IN_BITS +: BEAT_WIDTH_IN_BITS];
         beat_last_d = (cnt_nxt == len_q);
      end
   end

   // State and output registers; reset discards any entry in flight at once.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q     <= ST_IDLE;
         entry_q     <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         beat_q      <= '0;
         beat_vld_q  <= 1'b0;
         beat_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         entry_q     <= entry_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         beat_q      <= beat_d;
         beat_vld_q  <= beat_vld_d;
         beat_last_q <= beat_last_d;
      end
   end

endmodule

// File: tb/tb_queue_entry_serializer.sv
module tb_queue_entry_serializer;
   import queue_entry_serializer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, flush, ack, push_vld, push_rdy, q_vld, issue_ack;
   req_t        push_dat, q_dat;
   logic [15:0] beat;
   logic        bvld, blast, busy;

   always #5 clk = ~clk;

   fifo_queue #(.DATA_WIDTH_IN_BITS($bits(req_t)), .DEPTH(4)) u_q (
      .clk_in(clk), .reset_n_in(rst_n), .push_valid_in(push_vld), .push_ready_out(push_rdy),
      .push_data_in(push_dat), .request_out(q_dat), .request_valid_out(q_vld),
      .issue_ack_in(issue_ack)
   );

   queue_entry_serializer dut (
      .clk_in(clk), .reset_n_in(rst_n), .flush_in(flush), .request_in(q_dat.data),
      .request_len_in(q_dat.len), .request_valid_in(q_vld), .issue_ack_out(issue_ack),
      .beat_out(beat), .beat_valid_out(bvld), .beat_last_out(blast),
      .beat_ack_in(ack), .busy_out(busy)
   );

   typedef struct packed { logic [15:0] beat; logic last; } exp_t;
   typedef struct { logic [63:0] data; logic [1:0] len; logic [15:0] exp_last; int exp_n; } vec_t;

   exp_t        exp_q[$];
   logic [15:0] exp_last_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          xfer_cnt = 0;
   bit          prev_acc = 1'b0;
   vec_t        vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock: called right after a negedge with inputs already driven.
   task automatic tick();
      exp_t e;
      logic [15:0] el;
      #1;
      if (flush && busy) begin
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.last) break;
         end
         if (exp_last_q.size() > 0) el = exp_last_q.pop_front();
      end
      if (bvld && ack && !flush) begin
         xfer_cnt++;
         if (exp_q.size() == 0) begin
            check("beat_expected", 0, 1);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", beat, e.beat);
            check("beat_last", blast, e.last);
            if (e.last) begin
               check("issue_ack_on_last", issue_ack, 1);
               if (exp_last_q.size() > 0) begin
                  el = exp_last_q.pop_front();
                  check("table_last_beat", beat, el);
               end
            end
         end
      end
      prev_acc = issue_ack && q_vld;
      @(negedge clk);
      if (prev_acc) check("accept_to_first_beat", bvld, 1);
   endtask

   task automatic push_entry(input logic [63:0] data, input logic [1:0] len, input logic [15:0] exp_last);
      bit   done = 1'b0;
      exp_t e;
      push_dat = '{len: len, data: data};
      push_vld = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         if (push_rdy) begin
            for (int k = 0; k <= int'(len); k++) begin
               e.beat = data[k*16 +: 16];
               e.last = (k == int'(len));
               exp_q.push_back(e);
            end
            exp_last_q.push_back(exp_last);
            done = 1'b1;
         end
         tick();
      end
      push_vld = 1'b0;
      if (!done) check("push_accepted", 0, 1);
   endtask

   task automatic drain(input int exp_n);
      int bubbles = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
         ack = 1'b1;
         if (seen && !bvld) bubbles++;
         if (bvld) seen = 1'b1;
         tick();
      end
      check("drain_complete", exp_q.size(), 0);
      check("beat_count", xfer_cnt, exp_n);
      check("bubbles", bubbles, 0);
   endtask

   task automatic wait_beat(input logic [15:0] value);
      bit found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bvld && beat == value) begin
            found = 1'b1;
            break;
         end
         ack = 1'b1;
         tick();
      end
      check("reach_beat", found, 1);
   endtask

   initial begin
      int stale;
      vecs[0] = '{64'h4444_3333_2222_1111, 2'd3, 16'h4444, 4};
      vecs[1] = '{64'hDEAD_BEEF_0000_ABCD, 2'd0, 16'hABCD, 1};
      vecs[2] = '{64'h0123_4567_89AB_CDEF, 2'd1, 16'h89AB, 2};
      vecs[3] = '{64'hFFFF_0000_FFFF_0000, 2'd2, 16'h0000, 3};
      vecs[4] = '{64'hA5A5_5A5A_1234_8765, 2'd2, 16'h5A5A, 3};

      rst_n = 1'b0; flush = 1'b0; ack = 1'b1; push_vld = 1'b0; push_dat = '0;
      repeat (2) @(negedge clk);
      check("rst_beat_valid", bvld, 0);
      check("rst_beat_last", blast, 0);
      check("rst_beat", beat, 0);
      check("rst_busy", busy, 0);
      check("rst_issue_ack", issue_ack, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Single entries of every length, each drained alone.
      foreach (vecs[v]) begin
         xfer_cnt = 0;
         push_entry(vecs[v].data, vecs[v].len, vecs[v].exp_last);
         drain(vecs[v].exp_n);
         check("idle_busy_after", busy, 0);
         check("idle_valid_after", bvld, 0);
      end

      // Back-to-back entries: 6 beats with no bubble.
      xfer_cnt = 0;
      push_entry(64'h8888_7777_6666_5555, 2'd3, 16'h8888);
      push_entry(64'h0000_0000_BBBB_AAAA, 2'd1, 16'hBBBB);
      drain(6);

      // Downstream stall on beat 1 for 5 cycles.
      xfer_cnt = 0;
      push_entry(64'h4444_3333_2222_1111, 2'd3, 16'h4444);
      wait_beat(16'h2222);
      ack = 1'b0;
      repeat (5) begin
         tick();
         check("stall_beat", beat, 16'h2222);
         check("stall_valid", bvld, 1);
         check("stall_issue_ack", issue_ack, 0);
      end
      drain(4);

      // Flush during beat 2; the queued follower must still go out intact.
      push_entry(64'h4444_3333_2222_1111, 2'd3, 16'h4444);
      push_entry(64'h0000_0000_BBBB_AAAA, 2'd1, 16'hBBBB);
      wait_beat(16'h3333);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("flush_valid", bvld, 0);
      check("flush_busy", busy, 0);
      check("flush_beat", beat, 0);
      check("flush_issue_ack", issue_ack, 1);
      xfer_cnt = 0;
      drain(2);

      // Asynchronous reset in the middle of an entry.
      push_entry(64'h1357_2468_ACE0_BDF1, 2'd3, 16'h1357);
      wait_beat(16'hACE0);
      #3 rst_n = 1'b0;
      #1;
      check("arst_valid", bvld, 0);
      check("arst_beat", beat, 0);
      check("arst_last", blast, 0);
      check("arst_busy", busy, 0);
      exp_q.delete();
      exp_last_q.delete();
      prev_acc = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      repeat (4) begin
         ack = 1'b1;
         if (bvld) stale++;
         tick();
      end
      check("no_stale_beats", stale, 0);
      xfer_cnt = 0;
      push_entry(64'h9999_8888_7777_6666, 2'd2, 16'h8888);
      drain(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
